// File: rtl/cas_lock_key_sequencer_if.sv
// Handshake/bus bundle between the key sequencer and its environment:
// key loading, sweep control, locked/oracle responses and run results.
interface cas_lock_key_sequencer_if #(
   parameter int unsigned KEY_W = 64,
   parameter int unsigned PI_W  = 36,
   parameter int unsigned CNT_W = 16
) ();
   logic             key_load;
   logic             key_sin_valid;
   logic             key_sin;
   logic             start;
   logic [KEY_W-1:0] key_out;
   logic             key_ready;
   logic [PI_W-1:0]  pattern_out;
   logic             locked_resp;
   logic             oracle_resp;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] mismatch_cnt;
   logic [PI_W-1:0]  first_fail;

   modport master (
      output key_load, key_sin_valid, key_sin, start, locked_resp, oracle_resp,
      input  key_out, key_ready, pattern_out, busy, done, pass, mismatch_cnt, first_fail
   );

   modport slave (
      input  key_load, key_sin_valid, key_sin, start, locked_resp, oracle_resp,
      output key_out, key_ready, pattern_out, busy, done, pass, mismatch_cnt, first_fail
   );
endinterface

// File: rtl/cas_lock_key_sequencer.sv
// Loads a candidate key serially, sweeps an LFSR pattern set over a locked
// netlist and its oracle, and reports mismatch count, pass and first failure.
module cas_lock_key_sequencer #(
   parameter int unsigned     KEY_W     = 64,
   parameter int unsigned     PI_W      = 36,
   parameter int unsigned     NUM_PAT   = 1024,
   parameter int unsigned     CNT_W     = 16,
   parameter logic [PI_W-1:0] LFSR_SEED = 36'h0_0000_0001
) (
   input  logic                     clk,
   input  logic                     rst,
   cas_lock_key_sequencer_if.slave  bus
);

   localparam int unsigned      BIT_W    = $clog2(KEY_W + 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(KEY_W - 1);
   localparam logic [CNT_W-1:0] LAST_PAT = CNT_W'(NUM_PAT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
   // Second tap of x^36 + x^25 + 1 (the first tap is the MSB).
   localparam int unsigned      LFSR_TAP = 24;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_ARMED = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic              busy_r;
   logic              busy_s;
   logic              done_r;
   logic              done_s;
   logic              enter_load_s;
   logic              enter_run_s;

   logic [KEY_W-1:0]  key_r;
   logic              key_ready_r;
   logic [BIT_W-1:0]  bit_cnt_r;

   logic [PI_W-1:0]   pattern_r;
   logic [CNT_W-1:0]  pat_cnt_r;
   logic [CNT_W-1:0]  mismatch_r;
   logic [CNT_W-1:0]  mismatch_nxt_s;
   logic [PI_W-1:0]   first_fail_r;
   logic              pass_r;
   logic              miss_s;

   function automatic logic [PI_W-1:0] lfsr_next_f(input logic [PI_W-1:0] v);
      return {v[PI_W-2:0], v[PI_W-1] ^ v[LFSR_TAP]};
   endfunction

   // FSM state register with registered busy/done decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
      end
   end

   // FSM next-state logic; key_load outranks start where both are legal.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.key_load) state_s = ST_LOAD;
            else              state_s = ST_IDLE;
         end
         ST_LOAD: begin
            if (bus.key_sin_valid && (bit_cnt_r == LAST_BIT)) state_s = ST_ARMED;
            else                                              state_s = ST_LOAD;
         end
         ST_ARMED, ST_DONE: begin
            if (bus.key_load)   state_s = ST_LOAD;
            else if (bus.start) state_s = ST_RUN;
            else                state_s = state_r;
         end
         ST_RUN: begin
            if (pat_cnt_r == LAST_PAT) state_s = ST_DONE;
            else                       state_s = ST_RUN;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // FSM outputs: status decode of the next state plus entry strobes.
   always_comb begin
      busy_s       = 1'b0;
      done_s       = 1'b0;
      enter_load_s = 1'b0;
      enter_run_s  = 1'b0;
      case (state_s)
         ST_LOAD, ST_RUN: busy_s = 1'b1;
         ST_DONE:         done_s = 1'b1;
         default:         busy_s = 1'b0;
      endcase
      if ((state_s == ST_LOAD) && (state_r != ST_LOAD)) enter_load_s = 1'b1;
      else                                              enter_load_s = 1'b0;
      if ((state_s == ST_RUN) && (state_r != ST_RUN))   enter_run_s = 1'b1;
      else                                              enter_run_s = 1'b0;
   end

   // Per-pattern compare with saturating mismatch count.
   always_comb begin
      miss_s         = 1'b0;
      mismatch_nxt_s = mismatch_r;
      if ((state_r == ST_RUN) && (bus.locked_resp != bus.oracle_resp)) begin
         miss_s = 1'b1;
         if (mismatch_r != CNT_MAX) mismatch_nxt_s = mismatch_r + CNT_ONE;
         else                       mismatch_nxt_s = mismatch_r;
      end else begin
         miss_s         = 1'b0;
         mismatch_nxt_s = mismatch_r;
      end
   end

   // Key holding register: bits enter at the MSB, so the first bit ends in bit 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_r       <= {KEY_W{1'b0}};
         key_ready_r <= 1'b0;
         bit_cnt_r   <= {BIT_W{1'b0}};
      end else if (enter_load_s) begin
         key_r       <= {KEY_W{1'b0}};
         key_ready_r <= 1'b0;
         bit_cnt_r   <= {BIT_W{1'b0}};
      end else if ((state_r == ST_LOAD) && bus.key_sin_valid) begin
         key_r       <= {bus.key_sin, key_r[KEY_W-1:1]};
         key_ready_r <= (bit_cnt_r == LAST_BIT);
         bit_cnt_r   <= bit_cnt_r + BIT_ONE;
      end else begin
         key_r       <= key_r;
         key_ready_r <= key_ready_r;
         bit_cnt_r   <= bit_cnt_r;
      end
   end

   // Pattern sweep and result capture; first failure is taken while the count is still zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         pattern_r    <= LFSR_SEED;
         pat_cnt_r    <= {CNT_W{1'b0}};
         mismatch_r   <= {CNT_W{1'b0}};
         first_fail_r <= {PI_W{1'b0}};
         pass_r       <= 1'b0;
      end else if (enter_load_s) begin
         pattern_r    <= pattern_r;
         pat_cnt_r    <= pat_cnt_r;
         mismatch_r   <= {CNT_W{1'b0}};
         first_fail_r <= {PI_W{1'b0}};
         pass_r       <= 1'b0;
      end else if (enter_run_s) begin
         pattern_r    <= LFSR_SEED;
         pat_cnt_r    <= {CNT_W{1'b0}};
         mismatch_r   <= {CNT_W{1'b0}};
         first_fail_r <= {PI_W{1'b0}};
         pass_r       <= 1'b0;
      end else if (state_r == ST_RUN) begin
         pattern_r  <= lfsr_next_f(pattern_r);
         pat_cnt_r  <= pat_cnt_r + CNT_ONE;
         mismatch_r <= mismatch_nxt_s;
         if (miss_s && (mismatch_r == {CNT_W{1'b0}})) first_fail_r <= pattern_r;
         else                                         first_fail_r <= first_fail_r;
         pass_r <= (state_s == ST_DONE) && (mismatch_nxt_s == {CNT_W{1'b0}});
      end else begin
         pattern_r    <= pattern_r;
         pat_cnt_r    <= pat_cnt_r;
         mismatch_r   <= mismatch_r;
         first_fail_r <= first_fail_r;
         pass_r       <= pass_r;
      end
   end

   assign bus.key_out      = key_r;
   assign bus.key_ready    = key_ready_r;
   assign bus.pattern_out  = pattern_r;
   assign bus.busy         = busy_r;
   assign bus.done         = done_r;
   assign bus.pass         = pass_r;
   assign bus.mismatch_cnt = mismatch_r;
   assign bus.first_fail   = first_fail_r;

endmodule

// File: tb/tb_cas_lock_key_sequencer.sv
// Randomized bench for the key sequencer: a behavioural model replays the
// pattern sweep and fault predicate to predict count, pass and first failure.
module tb_cas_lock_key_sequencer;

   localparam logic [35:0] SEED = 36'h1;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   logic [63:0] cur_key;
   int          mode;
   logic [35:0] resp_mask;
   logic [35:0] target;
   logic [35:0] modv;
   logic [35:0] remv;
   logic        oracle_s;
   logic        locked_s;

   cas_lock_key_sequencer_if #(.KEY_W(64), .PI_W(36), .CNT_W(16)) ifa ();
   cas_lock_key_sequencer_if #(.KEY_W(64), .PI_W(36), .CNT_W(4))  ifb ();

   cas_lock_key_sequencer #(.KEY_W(64), .PI_W(36), .NUM_PAT(1024), .CNT_W(16)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa.slave)
   );

   cas_lock_key_sequencer #(.KEY_W(64), .PI_W(36), .NUM_PAT(16), .CNT_W(4)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic flip_f(input logic [35:0] p);
      case (mode)
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return (p == target);
         default: return ((p % modv) == remv);
      endcase
   endfunction

   function automatic logic [35:0] lfsr_step(input logic [35:0] p);
      return {p[34:0], p[35] ^ p[24]};
   endfunction

   always_comb begin
      oracle_s = ^(ifa.pattern_out & resp_mask);
      locked_s = oracle_s ^ flip_f(ifa.pattern_out);
   end
   assign ifa.oracle_resp = oracle_s;
   assign ifa.locked_resp = locked_s;
   assign ifb.oracle_resp = 1'b0;
   assign ifb.locked_resp = 1'b1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_a(input string tag);
      check_eq({tag, "_key_out"},   64'(ifa.key_out),      64'h0);
      check_eq({tag, "_key_ready"}, 64'(ifa.key_ready),    64'h0);
      check_eq({tag, "_pattern"},   64'(ifa.pattern_out),  64'(SEED));
      check_eq({tag, "_busy"},      64'(ifa.busy),         64'h0);
      check_eq({tag, "_done"},      64'(ifa.done),         64'h0);
      check_eq({tag, "_pass"},      64'(ifa.pass),         64'h0);
      check_eq({tag, "_mismatch"},  64'(ifa.mismatch_cnt), 64'h0);
      check_eq({tag, "_first_fail"},64'(ifa.first_fail),   64'h0);
   endtask

   // Serial key load into DUT A with idle gaps; optionally pokes start mid-load.
   task automatic load_key_a(input logic [63:0] key, input int gmin, input int gmax,
                             input bit poke_start);
      ifa.key_load = 1'b1;
      tick();
      ifa.key_load = 1'b0;
      for (int i = 0; i < 64; i++) begin
         int gap;
         gap = $urandom_range(gmax, gmin);
         for (int g = 0; g < gap; g++) begin
            ifa.key_sin = 1'($urandom);
            tick();
         end
         if (poke_start && i == 32) begin
            ifa.start = 1'b1;
            tick();
            ifa.start = 1'b0;
            check_eq("mid_load_start_busy", 64'(ifa.busy), 64'h1);
            check_eq("mid_load_start_done", 64'(ifa.done), 64'h0);
         end
         if (i == 63) check_eq("key_ready_before_last", 64'(ifa.key_ready), 64'h0);
         ifa.key_sin_valid = 1'b1;
         ifa.key_sin       = key[i];
         tick();
         ifa.key_sin_valid = 1'b0;
      end
      cur_key = key;
      check_eq("key_out",       ifa.key_out,         key);
      check_eq("key_ready",     64'(ifa.key_ready),  64'h1);
      check_eq("armed_busy",    64'(ifa.busy),       64'h0);
   endtask

   // One sweep on DUT A compared against the behavioural model.
   task automatic run_a(input string tag);
      logic [15:0] exp_cnt;
      logic [35:0] exp_ff;
      logic [35:0] p;
      int          cycles;
      exp_cnt = 16'h0;
      exp_ff  = 36'h0;
      p       = SEED;
      for (int k = 0; k < 1024; k++) begin
         if (flip_f(p)) begin
            if (exp_cnt == 16'h0) exp_ff = p;
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h1;
         end
         p = lfsr_step(p);
      end
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      check_eq({tag, "_first_pattern"}, 64'(ifa.pattern_out), 64'(SEED));
      check_eq({tag, "_busy"},          64'(ifa.busy),        64'h1);
      cycles = 0;
      while (!ifa.done && cycles < 1100) begin
         tick();
         cycles++;
         if (cycles == 1) check_eq({tag, "_second_pattern"}, 64'(ifa.pattern_out), 64'h2);
         if (cycles == 512) check_eq({tag, "_key_steady"}, ifa.key_out, cur_key);
      end
      check_eq({tag, "_done_latency"}, 64'(cycles),              64'd1024);
      check_eq({tag, "_mismatch"},     64'(ifa.mismatch_cnt),    64'(exp_cnt));
      check_eq({tag, "_pass"},         64'(ifa.pass),            64'(exp_cnt == 16'h0));
      check_eq({tag, "_first_fail"},   64'(ifa.first_fail),      64'(exp_ff));
      check_eq({tag, "_next_pattern"}, 64'(ifa.pattern_out),     64'(p));
      check_eq({tag, "_idle_busy"},    64'(ifa.busy),            64'h0);
   endtask

   initial begin
      int cycles;
      n_cmp = 0;
      n_bad = 0;
      mode = 0;
      resp_mask = 36'h0_0000_0000;
      target = 36'h0;
      modv = 36'h1;
      remv = 36'h0;
      cur_key = 64'h0;
      rst = 1'b1;
      ifa.key_load = 1'b0; ifa.key_sin_valid = 1'b0; ifa.key_sin = 1'b0; ifa.start = 1'b0;
      ifb.key_load = 1'b0; ifb.key_sin_valid = 1'b0; ifb.key_sin = 1'b0; ifb.start = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check_reset_a("reset");

      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      check_eq("idle_start_busy", 64'(ifa.busy), 64'h0);
      check_eq("idle_start_done", 64'(ifa.done), 64'h0);

      load_key_a(64'h1, 3, 3, 1'b1);

      resp_mask = 36'({$urandom, $urandom});
      mode = 0;
      run_a("clean");
      mode = 1;
      run_a("all_miss");
      mode = 2;
      target = 36'h8;
      run_a("single");
      run_a("single_again");

      for (int it = 0; it < 4; it++) begin
         load_key_a({$urandom, $urandom}, 0, 2, 1'b0);
         resp_mask = 36'({$urandom, $urandom});
         mode = 3;
         modv = 36'($urandom_range(40, 2));
         remv = 36'($urandom_range(32'(modv) - 1, 0));
         run_a("random");
      end

      // Small-counter instance: saturation and key_load/start priority.
      ifb.key_load = 1'b1;
      tick();
      ifb.key_load = 1'b0;
      ifb.key_sin_valid = 1'b1;
      for (int i = 0; i < 64; i++) begin
         ifb.key_sin = 1'($urandom);
         tick();
      end
      ifb.key_sin_valid = 1'b0;
      check_eq("b_key_ready", 64'(ifb.key_ready), 64'h1);
      ifb.start = 1'b1;
      tick();
      ifb.start = 1'b0;
      cycles = 0;
      while (!ifb.done && cycles < 40) begin
         tick();
         cycles++;
      end
      check_eq("b_done_latency", 64'(cycles),           64'd16);
      check_eq("b_saturated",    64'(ifb.mismatch_cnt), 64'd15);
      check_eq("b_pass",         64'(ifb.pass),         64'h0);
      check_eq("b_first_fail",   64'(ifb.first_fail),   64'(SEED));
      ifb.key_load = 1'b1;
      ifb.start    = 1'b1;
      tick();
      ifb.key_load = 1'b0;
      ifb.start    = 1'b0;
      check_eq("b_prio_busy",      64'(ifb.busy),      64'h1);
      check_eq("b_prio_done",      64'(ifb.done),      64'h0);
      check_eq("b_prio_key_ready", 64'(ifb.key_ready), 64'h0);
      check_eq("b_prio_key_out",   ifb.key_out,        64'h0);

      // Abort mid-run on DUT A.
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      for (int i = 0; i < 500; i++) tick();
      check_eq("abort_pre_busy", 64'(ifa.busy), 64'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_a("abort");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cas_lock_key_sequencer.md
Name: cas_lock_key_sequencer

Overview:
- Controller that configures and exercises a key-locked combinational benchmark, such as a CAS-Lock-protected c432 with a 64-bit key and 36 primary inputs.
- Serially loads the key into a holding register and drives it onto the locked netlist's key inputs.
- Sweeps an LFSR pattern set across the primary inputs and compares the locked output against an unlocked oracle copy each cycle.
- Reports mismatch count, pass/fail and the first failing pattern; used on-chip and in simulation to validate candidate keys from attack runs.

Parameters:
- KEY_W, 64, key width; length of the key shift register.
- PI_W, 36, primary-input width; LFSR width.
- NUM_PAT, 1024, patterns applied per run (1..2^CNT_W).
- CNT_W, 16, mismatch/pattern counter width.
- LFSR_SEED, 36'h0_0000_0001, LFSR start value; must be nonzero.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- key_load  input  1  pulse; begin serial key load.
- key_sin_valid  input  1  qualifies key_sin.
- key_sin  input  1  serial key bit.
- start  input  1  pulse; begin pattern sweep.
- key_out  output  KEY_W  key register, to the locked netlist's key inputs.
- key_ready  output  1  full key held.
- pattern_out  output  PI_W  registered pattern, to both locked and oracle netlists.
- locked_resp  input  1  locked netlist output, combinational from pattern_out/key_out.
- oracle_resp  input  1  oracle netlist output, combinational from pattern_out.
- busy  output  1  high in LOAD or RUN.
- done  output  1  high in DONE.
- pass  output  1  valid in DONE; 1 iff mismatch_cnt==0.
- mismatch_cnt  output  CNT_W  mismatching patterns, saturating.
- first_fail  output  PI_W  pattern of the first mismatch; 0 if none.

Behaviour:
- Reset (rst=1 at an edge, from any state): state=IDLE; key_out=0; key_ready=0; pattern_out=LFSR_SEED; busy=0; done=0; pass=0; mismatch_cnt=0; first_fail=0; bit and pattern counters=0.
- States and transitions:
  - IDLE: key_load -> LOAD.
  - LOAD: collects bits; the KEY_W-th valid bit -> ARMED.
  - ARMED: start -> RUN; key_load -> LOAD.
  - RUN: after NUM_PAT compares -> DONE.
  - DONE: start -> RUN; key_load -> LOAD.
- Priority: if key_load and start are asserted together, key_load wins.
- Ignored inputs: start in IDLE/LOAD/RUN; key_load in LOAD/RUN.
- Entering LOAD clears key_out, key_ready and the bit counter.
- Key shift: each key_sin_valid cycle in LOAD, key_out <= {key_sin, key_out[KEY_W-1:1]}. The first bit sent ends in key_out[0], the last in key_out[KEY_W-1]. key_sin_valid outside LOAD has no effect.
- key_ready rises in the same edge as LOAD->ARMED and stays high until the next LOAD or reset.
- Entering RUN: pattern_out=LFSR_SEED, counters=0, first_fail=0, pass=0, done=0.
- Each RUN cycle:
  - Compare locked_resp vs oracle_resp for the current pattern_out.
  - On mismatch, increment mismatch_cnt, saturating at 2^CNT_W-1.
  - On the first mismatch of the run, capture first_fail=pattern_out.
  - Advance pattern_out <= {pattern_out[PI_W-2:0], pattern_out[35]^pattern_out[24]} (x^36+x^25+1).
  - Increment the pattern counter.
- The compare for pattern k happens in RUN cycle k. The NUM_PAT-th compare edge moves the block to DONE. The pattern after the last is loaded but not compared.
- Throughput and latency: one pattern per cycle. With start seen at edge t, done=1 after edge t+NUM_PAT.
- In DONE, pass=(mismatch_cnt==0). All results hold until the next RUN entry, LOAD entry or reset.
- key_out is constant throughout RUN.
- Reset mid-LOAD or mid-RUN aborts immediately to reset values. No partial results are kept.

Test Plan:
- Key shift: reset; key_load; 64 valid bits, first=1, rest=0, with key_sin_valid gaps of 3 cycles -> key_out=64'h1, key_ready=1 exactly after the 64th valid bit.
- Clean run: tie locked_resp=oracle_resp; start -> pattern_out=36'h1 in the first RUN cycle, 36'h2 next; done=1 exactly 1024 cycles after start; pass=1, mismatch_cnt=0, first_fail=0.
- Full mismatch: locked_resp=~oracle_resp -> mismatch_cnt=1024, pass=0, first_fail=36'h1.
- Single fail: oracle inverted only when pattern_out==36'h8 -> mismatch_cnt=1, first_fail=36'h8; a re-issued start clears and reproduces the same result.
- Saturation: CNT_W=4, NUM_PAT=16, always mismatch -> mismatch_cnt=15. Then key_load+start in the same cycle from DONE -> LOAD, key_ready=0.
- Abort: rst at RUN cycle 500 -> all outputs at reset values next cycle. A start pulse in IDLE or mid-LOAD is ignored (busy, done unchanged).
